mul_inv_kn: RTL and testbench
=============================

# mul_inv_kn

Sequential gain-restoring multiplier for the pipeline CORDIC processor: multiplies a signed fixed-point (12:10) sample by 1/Kn ≈ 1.6465 (1686/1024), undoing the Kn gain-compensation scaling applied by the Kn multiplier blocks. It is used on the inverse path, where pre-compensated coordinates re-enter the datapath. It uses one shift-add term per cycle, with valid/ready handshakes on both sides and saturation to W bits.

## Interface
- W, 12, sample width (fixed-point 12:10)
- FXP_SHIFT, 10, fraction bits
- ROUND, 0, 0 = truncate (arithmetic shift, toward −∞); 1 = add 2^(FXP_SHIFT−1) before the shift
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; overrides ce
- ce  in  1  clock enable; when 0, no register changes and no transfer occurs
- in_valid  in  1  value_in/bypass_in valid
- in_ready  out  1  combinational: (state==IDLE) & ce
- value_in  in  W  signed input sample
- bypass_in  in  1  1 = pass value_in unscaled (t_angle==0 case)
- out_valid  out  1  registered; value_out valid
- out_ready  in  1  downstream accepts value_out
- value_out  out  W  signed result, held stable while out_valid & !out_ready

## Operation
- Constant 1686 = 2^10+2^9+2^7+2^4+2^2+2^1, so the shift sequence is {10,9,7,4,2,1} (6 terms).
- States: IDLE, ACC, DONE.
- IDLE: on an edge with ce & in_valid (input transfer):
  - latch x=value_in (sign-extended to 2W) and byp=bypass_in;
  - acc<=0, cnt<=0, go to ACC.
- ACC: on each ce edge, acc<=acc+(x<<<shift[cnt]) and cnt++.
  - On the edge with cnt==5, the final sum s is formed and the block goes to DONE.
  - value_out<=sat((s + ROUND·2^(FXP_SHIFT−1)) >>> FXP_SHIFT), or value_out<=x[W−1:0] if byp.
  - out_valid<=1.
- DONE: on a ce edge with out_ready: out_valid<=0, go to IDLE.
  - No input is accepted in the same edge; in_ready is 0 in DONE.
- Arithmetic and saturation:
  - Accumulator is 2W bits signed; the maximum |x·1686| < 2^22 fits for W=12.
  - sat clamps to [−2^(W−1), 2^(W−1)−1].
  - Bypass never saturates.
- Reset, including mid-ACC or mid-DONE:
  - state=IDLE, out_valid=0, value_out=0, acc=0, cnt=0;
  - the in-flight sample is discarded.
- ce=0 mid-operation freezes state, cnt and acc.
  - out_valid and value_out hold.
  - in_ready drops to 0.

## Timing
- Latency: the input transfer edge is E0; out_valid rises after E6 (6 edges with ce=1 after acceptance).
- Throughput: one sample per 8 ce-cycles with out_ready held 1.
  - The 8 edges are: accept, 6×ACC, output transfer; the next accept follows on the edge after return to IDLE.
- Output transfer occurs on an edge with ce & out_valid & out_ready.
- value_out changes only on the edge entering DONE.
- in_valid is ignored outside IDLE.
  - The source must hold value_in until in_ready & in_valid coincide on a ce edge.
- out_ready has no combinational path to in_ready.

## Structure
- Shared include cordic_defs.vh contains:
  - the state encoding (IDLE=0, ACC=1, DONE=2);
  - the INV_KN shift list {10,9,7,4,2,1} and INV_KN_TERMS=6;
  - FXP_SHIFT default 10.
- The shift list is selected by a cnt-indexed case in the RTL; it is not stored as a parameter array.
- One sub-module, sat_round: a combinational rounding/arithmetic-shift/saturation stage.
  - Parameters W, FXP_SHIFT, ROUND.
  - Reusable by other CORDIC output stages.

## Test plan
- Nominal: value_in=1024 (1.0), out_ready=1.
  - value_out=1686, out_valid high exactly 6 ce-edges after acceptance; in_ready=0 throughout.
  - value_in=−1024 gives −1686.
- Round-trip: value_in=621 (Kn) gives 1022 with ROUND=0 and 1022 with ROUND=1.
  - value_in=−1 gives −2 in both modes.
- Saturation:
  - value_in=2047 gives 2047;
  - value_in=−2048 gives −2048;
  - value_in=1300 gives 2047 (2140 unclamped).
- Bypass and backpressure: bypass_in=1, value_in=−700 gives −700 with the same latency.
  - With out_ready=0 for 5 cycles, out_valid and value_out hold and in_ready stays 0.
  - After out_ready rises, in_ready returns 1 on the next cycle.
- ce gating: ce=0 for 3 cycles in the middle of ACC extends latency by exactly 3 cycles; the result is unchanged (1686 for 1024).
- Reset mid-operation: reset asserted in ACC (cnt=3).
  - Next cycle: out_valid=0, value_out=0, in_ready=1.
  - A fresh sample 512 then gives 843.

Source files
------------

// File: rtl/mul_inv_kn_pkg.sv
// Shared definitions for the 1/Kn gain-restoring multiplier.
// Holds the FSM state encoding, the number of shift-add terms, the default
// fraction width and the cnt-indexed shift lookup for 1686 = 1.6465 * 1024.
package mul_inv_kn_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int INV_KN_TERMS  = 6;
  localparam int FXP_SHIFT_DEF = 10;

  // 1686 = 2^10 + 2^9 + 2^7 + 2^4 + 2^2 + 2^1, one term per accumulate cycle.
  function automatic logic [3:0] inv_kn_shift(input logic [2:0] cnt);
    logic [3:0] sh;
    case (cnt)
      3'd0:    sh = 4'd10;
      3'd1:    sh = 4'd9;
      3'd2:    sh = 4'd7;
      3'd3:    sh = 4'd4;
      3'd4:    sh = 4'd2;
      3'd5:    sh = 4'd1;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul_inv_kn_sat_round.sv
// sat_round: combinational round / arithmetic-shift / saturate stage.
// Takes a 2W-bit signed product, optionally adds half an LSB of the output,
// shifts right arithmetically by FXP_SHIFT and clamps to W signed bits.
// Ports:
//   din  in  2W  signed full-precision value
//   dout out W   signed rounded, shifted, saturated value
module sat_round
  import mul_inv_kn_pkg::*;
#(
  parameter int W         = 12,
  parameter int FXP_SHIFT = FXP_SHIFT_DEF,
  parameter int ROUND     = 0
) (
  input  logic [2*W-1:0] din,
  output logic [W-1:0]   dout
);

  // One guard bit so the rounding bias can never wrap the sum.
  localparam int XW = 2*W + 1;
  localparam logic signed [XW-1:0] ONE_C = XW'(1);
  localparam logic signed [XW-1:0] RND_C = (ROUND != 0) ? (ONE_C <<< (FXP_SHIFT-1)) : '0;
  localparam logic signed [XW-1:0] MAX_C = (ONE_C <<< (W-1)) - ONE_C;
  localparam logic signed [XW-1:0] MIN_C = -(ONE_C <<< (W-1));

  logic signed [XW-1:0] ext_s;
  logic signed [XW-1:0] shifted_s;

  assign ext_s     = $signed({din[2*W-1], din}) + RND_C;
  assign shifted_s = ext_s >>> FXP_SHIFT;

  // Clamp the shifted value into the signed W-bit range.
  always_comb begin
    dout = shifted_s[W-1:0];
    if (shifted_s > MAX_C) begin
      dout = MAX_C[W-1:0];
    end else if (shifted_s < MIN_C) begin
      dout = MIN_C[W-1:0];
    end else begin
      dout = shifted_s[W-1:0];
    end
  end

endmodule

// File: rtl/mul_inv_kn.sv
// mul_inv_kn: sequential multiply of a signed 12:10 sample by 1/Kn (1686/1024),
// one shift-add term per enabled cycle, saturated to W bits.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   ce              clock enable, freezes all state when low
//   in_valid/in_ready, value_in, bypass_in   input handshake and sample
//   out_valid/out_ready, value_out           output handshake and result
module mul_inv_kn
  import mul_inv_kn_pkg::*;
#(
  parameter int W         = 12,
  parameter int FXP_SHIFT = FXP_SHIFT_DEF,
  parameter int ROUND     = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] value_in,
  input  logic         bypass_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] value_out
);

  logic [1:0]           state_r;
  logic [2:0]           cnt_r;
  logic signed [2*W-1:0] acc_r;
  logic signed [2*W-1:0] x_r;
  logic                 byp_r;
  logic                 out_valid_r;
  logic [W-1:0]         value_out_r;

  logic [3:0]           shift_s;
  logic signed [2*W-1:0] sum_s;
  logic [W-1:0]         sat_s;

  // Current term x * 2^shift[cnt] added to the running sum.
  always_comb begin
    shift_s = inv_kn_shift(cnt_r);
    sum_s   = acc_r + (x_r <<< shift_s);
  end

  sat_round #(
    .W         (W),
    .FXP_SHIFT (FXP_SHIFT),
    .ROUND     (ROUND)
  ) u_sat_round (
    .din  (sum_s),
    .dout (sat_s)
  );

  // Handshake FSM and shift-add datapath; ce low holds everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      acc_r       <= '0;
      x_r         <= '0;
      byp_r       <= 1'b0;
      out_valid_r <= 1'b0;
      value_out_r <= '0;
    end else if (ce) begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r     <= {{W{value_in[W-1]}}, value_in};
            byp_r   <= bypass_in;
            acc_r   <= '0;
            cnt_r   <= 3'd0;
            state_r <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'(INV_KN_TERMS - 1)) begin
            // The sum formed on this edge is the complete product.
            value_out_r <= byp_r ? x_r[W-1:0] : sat_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE) & ce;
  assign out_valid = out_valid_r;
  assign value_out = value_out_r;

endmodule

// File: tb/tb_mul_inv_kn.sv
// Self-checking bench for mul_inv_kn: directed corner samples plus random
// samples, checked against an arithmetic model of v * 1686 / 1024 with floor
// or round-half-up, clamped to 12 bits. Two instances cover ROUND=0 and 1.
module tb_mul_inv_kn;

  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset;
  logic         ce;
  logic         in_valid;
  logic [W-1:0] value_in;
  logic         bypass_in;
  logic         out_ready;
  logic         in_ready0, in_ready1;
  logic         out_valid0, out_valid1;
  logic [W-1:0] value_out0, value_out1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mul_inv_kn #(.W(W), .FXP_SHIFT(10), .ROUND(0)) dut_trunc (
    .clock(clock), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready0),
    .value_in(value_in), .bypass_in(bypass_in),
    .out_valid(out_valid0), .out_ready(out_ready),
    .value_out(value_out0)
  );

  mul_inv_kn #(.W(W), .FXP_SHIFT(10), .ROUND(1)) dut_round (
    .clock(clock), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready1),
    .value_in(value_in), .bypass_in(bypass_in),
    .out_valid(out_valid1), .out_ready(out_ready),
    .value_out(value_out1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: v * 1.6465 in 12:10, floor division, clamp to 12 signed bits.
  function automatic int ref_mul(input int v, input bit byp, input bit rnd);
    int p, q;
    if (byp) return v;
    p = v * 1686 + (rnd ? 512 : 0);
    q = p / 1024;
    if (p < 0 && (p % 1024) != 0) q = q - 1;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transaction: accept, count cycles to out_valid (with an optional ce
  // gap), hold under backpressure, then transfer out.
  task automatic run_sample(input int v, input bit byp, input int bp, input int gap);
    int cycles;
    int e0, e1;
    int held;
    ce = 1'b1;
    cycles = 0;
    while (!in_ready0 && cycles < 12) begin
      tick();
      cycles++;
    end
    check("ready_before_accept", int'(in_ready0), 1);
    in_valid  = 1'b1;
    value_in  = W'(v);
    bypass_in = byp;
    out_ready = (bp == 0);
    tick();
    // Garbage while busy must be ignored.
    in_valid  = 1'b1;
    value_in  = W'($urandom);
    bypass_in = 1'($urandom);
    cycles = 0;
    while (!out_valid0 && cycles < 40) begin
      check("in_ready_busy", int'(in_ready0), 0);
      ce = !(cycles >= 2 && cycles < 2 + gap);
      tick();
      cycles++;
    end
    ce = 1'b1;
    in_valid = 1'b0;
    check("latency", cycles, 6 + gap);
    check("valid_round_inst", int'(out_valid1), 1);
    e0 = ref_mul(v, byp, 1'b0);
    e1 = ref_mul(v, byp, 1'b1);
    check("value_trunc", int'($signed(value_out0)), e0);
    check("value_round", int'($signed(value_out1)), e1);
    check("in_ready_done", int'(in_ready0), 0);
    held = int'($signed(value_out0));
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid_hold", int'(out_valid0), 1);
      check("bp_value_hold", int'($signed(value_out0)), held);
      check("bp_in_ready", int'(in_ready0), 0);
    end
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", int'(out_valid0), 0);
    check("in_ready_return", int'(in_ready0), 1);
  endtask

  initial begin
    int v;
    bit byp;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; value_in = '0;
    bypass_in = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", int'(out_valid0), 0);
    check("rst_value_out", int'($signed(value_out0)), 0);
    check("rst_in_ready", int'(in_ready0), 1);

    run_sample(1024, 1'b0, 0, 0);
    run_sample(-1024, 1'b0, 0, 0);
    run_sample(621, 1'b0, 0, 0);
    run_sample(-1, 1'b0, 0, 0);
    run_sample(2047, 1'b0, 0, 0);
    run_sample(-2048, 1'b0, 0, 0);
    run_sample(1300, 1'b0, 0, 0);
    run_sample(-700, 1'b1, 5, 0);
    run_sample(1024, 1'b0, 0, 3);

    // Spot-check absolute values quoted for the corner samples.
    check("kn_roundtrip", ref_mul(621, 1'b0, 1'b1), 1022);

    // Reset mid-ACC after three accumulate edges.
    in_valid = 1'b1; value_in = W'(1024); bypass_in = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", int'(out_valid0), 0);
    check("midrst_value_out", int'($signed(value_out0)), 0);
    check("midrst_in_ready", int'(in_ready0), 1);
    run_sample(512, 1'b0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      v   = int'($urandom_range(4095)) - 2048;
      byp = ($urandom_range(7) == 0);
      run_sample(v, byp, int'($urandom_range(3)), int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
